calendar_core: RTL
==================

# calendar_core

Calendar stage of the alarm clock. It consumes the one-cycle day-rollover tick from the hours counter and the set-mode advance buttons. It maintains month (1–12), date (1–month length) and day-of-week (0–6), and drives BCD digit pairs to the month/date/day 7-segment decoders in the top level. There are no leap years: February always has `FEB_DAYS` days.

## Interface
- `FEB_DAYS`, default 28: length of February; legal values 28 or 29.
- `Clk`  in  1: system clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high; highest priority.
- `day_tick`  in  1: one-cycle pulse from the hours counter on 23:59:59→00:00:00.
- `Timeset`  in  1: set mode; while high, advance buttons are honoured and `day_tick` is ignored.
- `Dateadv`  in  1: level; in set mode, date +1 on every cycle it is high.
- `Monthadv`  in  1: level; in set mode, month +1 on every cycle it is high.
- `Dayadv`  in  1: level; in set mode, day-of-week +1 on every cycle it is high.
- `month`  out  4: binary month, 1–12.
- `date`  out  5: binary date, 1–31.
- `day`  out  3: day-of-week, 0–6 (0 = Sunday).
- `Month1`, `Month0`  out  4 each: BCD tens and units of `month`.
- `Date1`, `Date0`  out  4 each: BCD tens and units of `date`.
- `year_tick`  out  1: registered one-cycle pulse on Dec 31→Jan 1 in normal mode.

## Operation
- Month length `L(m)` = 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11; `FEB_DAYS` for month 2.
- Reset: month=1, date=1, day=0, year_tick=0. BCD outputs therefore read 0,1,0,1.
- **Normal mode** (Timeset=0): advance buttons are ignored.
  - On `day_tick`=1: day ← (day+1) mod 7.
  - If date < L(month): date ← date+1.
  - Otherwise: date ← 1, and month ← month+1; month 12 wraps to 1, and that wrap raises `year_tick` for that cycle.
- **Set mode** (Timeset=1): `day_tick` is ignored. Each cycle:
  - next_month = Monthadv ? (month==12 ? 1 : month+1) : month.
  - With L' = L(next_month):
    - If Dateadv: date ← (date ≥ L') ? 1 : date+1.
    - Otherwise: date ← min(date, L'). This clamps the date when the month shrinks.
  - Set-mode date wrap never carries into the month.
  - If Dayadv: day ← (day+1) mod 7. Day-of-week is independent of date.
  - year_tick is 0 in set mode.
- All three buttons may be high in the same cycle; each applies as above in that one cycle.
- Month/date values are never outside their legal range, including immediately after reset and after any clamp.

## Timing
- Single clock domain. State registers are updated one cycle after the inputs are sampled high.
- BCD outputs are combinational from the registered month/date: same cycle as the binary values, no extra latency.
- `year_tick` is registered and asserted in the cycle following the `day_tick` that produced Jan 1, i.e. coincident with month=1/date=1 becoming visible.
- Holding an advance button for N cycles yields exactly N increments (with wrap).
- Reset asserted mid-operation (including during set mode with buttons held) forces reset values on the next edge. Buttons still high after Reset drops resume incrementing from the reset values on the following edge.
- `day_tick` coincident with Timeset=1 is dropped, not deferred.

## Structure
- Package `calendar_pkg` holds:
  - `month_t` (logic [3:0]), `date_t` (logic [4:0]), `dow_t` (logic [2:0]).
  - A `month_len(month_t m, int feb)` function returning `date_t`.
  - Constants `MONTHS=12` and `DAYS_PER_WEEK=7`.
- Sub-module `bin2bcd_2d`: 5-bit binary (0–31) → two BCD digits, purely combinational. It is instantiated twice (month, date).
- The next-state logic is one `always_ff` with a combinational next-value block. There is no explicit FSM; mode is Timeset.

## Test plan
- Reset, then Timeset=1, Monthadv high 11 cycles and Dateadv high 30 cycles (overlapping), release → month=12, date=31, BCD 1,2,3,1.
- From Dec 31, Timeset=0, one `day_tick` → month=1, date=1, day+1 mod 7, year_tick high for exactly one cycle.
- Set Feb 28, one `day_tick` → 03/01. Set Apr 30, one `day_tick` → 05/01. Rebuild with FEB_DAYS=29 and start from Feb 28: one tick → 02/29, second tick → 03/01.
- At Jan 31 in set mode, Monthadv for 1 cycle → month=2, date clamped to 28. With Dateadv held 1 cycle at Feb 28 → date=1, month still 2.
- Timeset=1 with `day_tick` pulsed → no change. Dayadv held 9 cycles from day=0 → day=2.
- Buttons held with Reset pulsed mid-hold → 01/01, day 0 on the reset edge, then increments resume on the next edge.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared calendar types, constants and the month-length rule.
package calendar_pkg;

  typedef logic [3:0] month_t;
  typedef logic [4:0] date_t;
  typedef logic [2:0] dow_t;

  localparam int MONTHS        = 12;
  localparam int DAYS_PER_WEEK = 7;

  function automatic date_t month_len(month_t m, int feb);
    date_t len;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = date_t'(feb);
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational 0-31 binary to two BCD digits.
module bin2bcd_2d (
  input  logic [4:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  always_comb begin
    tens_o = 4'd0;
    ones_o = bin_i[3:0];
    if (bin_i >= 5'd30) begin
      tens_o = 4'd3;
      ones_o = 4'(bin_i - 5'd30);
    end else if (bin_i >= 5'd20) begin
      tens_o = 4'd2;
      ones_o = 4'(bin_i - 5'd20);
    end else if (bin_i >= 5'd10) begin
      tens_o = 4'd1;
      ones_o = 4'(bin_i - 5'd10);
    end
  end

endmodule

// File: rtl/calendar_core.sv
// Month/date/day-of-week calendar with set-mode advance buttons and BCD outputs.
module calendar_core
  import calendar_pkg::*;
#(
  parameter int FEB_DAYS = 28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       day_tick,
  input  logic       Timeset,
  input  logic       Dateadv,
  input  logic       Monthadv,
  input  logic       Dayadv,
  output logic [3:0] month,
  output logic [4:0] date,
  output logic [2:0] day,
  output logic [3:0] Month1,
  output logic [3:0] Month0,
  output logic [3:0] Date1,
  output logic [3:0] Date0,
  output logic       year_tick
);

  month_t month_q, month_d, month_inc, month_set;
  date_t  date_q, date_d, len_cur, len_set;
  dow_t   day_q, day_d, day_inc;
  logic   year_q, year_d;

  always_comb begin
    month_inc = (month_q == month_t'(MONTHS)) ? 4'd1 : month_q + 4'd1;
    day_inc   = (day_q == dow_t'(DAYS_PER_WEEK - 1)) ? 3'd0 : day_q + 3'd1;
    month_set = Monthadv ? month_inc : month_q;
    len_cur   = month_len(month_q, FEB_DAYS);
    len_set   = month_len(month_set, FEB_DAYS);

    month_d = month_q;
    date_d  = date_q;
    day_d   = day_q;
    year_d  = 1'b0;

    if (Timeset) begin
      month_d = month_set;
      // Date wraps/clamps against the length of the month being entered this cycle.
      if (Dateadv)
        date_d = (date_q >= len_set) ? 5'd1 : date_q + 5'd1;
      else if (date_q > len_set)
        date_d = len_set;
      if (Dayadv)
        day_d = day_inc;
    end else if (day_tick) begin
      day_d = day_inc;
      if (date_q < len_cur) begin
        date_d = date_q + 5'd1;
      end else begin
        date_d  = 5'd1;
        month_d = month_inc;
        year_d  = (month_q == month_t'(MONTHS));
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      month_q <= 4'd1;
      date_q  <= 5'd1;
      day_q   <= '0;
      year_q  <= 1'b0;
    end else begin
      month_q <= month_d;
      date_q  <= date_d;
      day_q   <= day_d;
      year_q  <= year_d;
    end
  end

  assign month     = month_q;
  assign date      = date_q;
  assign day       = day_q;
  assign year_tick = year_q;

  bin2bcd_2d u_month_bcd (
    .bin_i  ({1'b0, month_q}),
    .tens_o (Month1),
    .ones_o (Month0)
  );

  bin2bcd_2d u_date_bcd (
    .bin_i  (date_q),
    .tens_o (Date1),
    .ones_o (Date0)
  );

endmodule
